// File: rtl/rename_regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : rename_regfile_mp_if
// Purpose  : Read, commit, rename and flush bundle for rename_regfile_mp.
// Revision : 1.0 - initial release
// ============================================================================
interface rename_regfile_mp_if #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 2,
  parameter int COMMIT_W = 2
);
  logic                       rdy;
  logic [NUM_RD*REG_AW-1:0]   rd_idx;
  logic [NUM_RD-1:0]          rd_ready;
  logic [NUM_RD*XLEN-1:0]     rd_val;
  logic [NUM_RD*TAG_W-1:0]    rd_tag;
  logic [COMMIT_W-1:0]        cm_valid;
  logic [COMMIT_W*REG_AW-1:0] cm_rd;
  logic [COMMIT_W*TAG_W-1:0]  cm_tag;
  logic [COMMIT_W*XLEN-1:0]   cm_val;
  logic                       up_valid;
  logic [REG_AW-1:0]          up_rd;
  logic [TAG_W-1:0]           up_tag;
  logic                       flush;
  logic [REG_AW:0]            busy_cnt;

  modport master (
    output rdy, rd_idx, cm_valid, cm_rd, cm_tag, cm_val, up_valid, up_rd, up_tag, flush,
    input  rd_ready, rd_val, rd_tag, busy_cnt
  );

  modport slave (
    input  rdy, rd_idx, cm_valid, cm_rd, cm_tag, cm_val, up_valid, up_rd, up_tag, flush,
    output rd_ready, rd_val, rd_tag, busy_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rename_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : rename_regfile_mp
// Purpose  : Multi-port architectural regfile with busy/tag rename status.
//            Optional same-cycle commit bypass: REGFILE_COMMIT_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rename_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int REG_AW   = 5,
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 2,
  parameter int COMMIT_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  rename_regfile_mp_if.slave  bus
);
  logic [XLEN-1:0]  val_q [NREG];
  logic [XLEN-1:0]  val_d [NREG];
  logic [TAG_W-1:0] tag_q [NREG];
  logic [TAG_W-1:0] tag_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [REG_AW:0]  busy_cnt_q, busy_cnt_d;

  always_comb begin : next_state
    logic [REG_AW-1:0] rd_p;
    logic              younger;
    logic              up_hit;
    val_d   = val_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    rd_p    = '0;
    younger = 1'b0;
    up_hit  = 1'b0;
    if (bus.rdy) begin
      // Ascending port order lets the youngest commit win the value write.
      for (int p = 0; p < COMMIT_W; p++) begin
        rd_p = bus.cm_rd[p*REG_AW +: REG_AW];
        if (bus.cm_valid[p] && rd_p != '0) begin
          val_d[rd_p] = bus.cm_val[p*XLEN +: XLEN];
          younger = 1'b0;
          for (int q = p + 1; q < COMMIT_W; q++) begin
            if (bus.cm_valid[q] && bus.cm_rd[q*REG_AW +: REG_AW] == rd_p) younger = 1'b1;
          end
          up_hit = bus.up_valid && (bus.up_rd == rd_p);
          if (tag_q[rd_p] == bus.cm_tag[p*TAG_W +: TAG_W] && !younger && !up_hit)
            busy_d[rd_p] = 1'b0;
        end
      end
      if (!bus.flush && bus.up_valid && bus.up_rd != '0) begin
        busy_d[bus.up_rd] = 1'b1;
        tag_d[bus.up_rd]  = bus.up_tag;
      end
    end
    if (bus.flush) busy_d = '0;
  end

  always_comb begin : popcount
    busy_cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_cnt_d = busy_cnt_d + {{REG_AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      val_q      <= val_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [REG_AW-1:0] idx;
    logic              byp_hit;
    logic [XLEN-1:0]   byp_val;

    assign idx = bus.rd_idx[k*REG_AW +: REG_AW];

`ifdef REGFILE_COMMIT_BYPASS_EN
    always_comb begin
      byp_hit = 1'b0;
      byp_val = '0;
      for (int p = 0; p < COMMIT_W; p++) begin
        if (bus.rdy && busy_q[idx] && bus.cm_valid[p] &&
            bus.cm_rd[p*REG_AW +: REG_AW] == idx &&
            bus.cm_tag[p*TAG_W +: TAG_W] == tag_q[idx]) begin
          byp_hit = 1'b1;
          byp_val = bus.cm_val[p*XLEN +: XLEN];
        end
      end
      // A same-cycle rename of this register makes the committed value stale.
      if (bus.up_valid && bus.up_rd == idx) byp_hit = 1'b0;
    end
`else
    assign byp_hit = 1'b0;
    assign byp_val = '0;
`endif

    assign bus.rd_ready[k] = (idx == '0) ? 1'b1 : (!busy_q[idx] || byp_hit);
    assign bus.rd_val[k*XLEN +: XLEN] = (idx == '0) ? '0 : (byp_hit ? byp_val : val_q[idx]);
    assign bus.rd_tag[k*TAG_W +: TAG_W] = (idx == '0) ? '0 : tag_q[idx];
  end
endmodule
`default_nettype wire

// File: tb/tb_rename_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_regfile_mp
// Purpose  : Directed and randomized checks of rename_regfile_mp against a
//            per-register behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rename_regfile_mp;
  localparam int XLEN = 32, NREG = 32, REG_AW = 5, TAG_W = 4, NUM_RD = 2, COMMIT_W = 2;

  logic clk, rst;
  int   checks = 0, errors = 0;
  bit   chk_en = 0;

  rename_regfile_mp_if #(.XLEN(XLEN), .REG_AW(REG_AW), .TAG_W(TAG_W),
                         .NUM_RD(NUM_RD), .COMMIT_W(COMMIT_W)) bus ();

  rename_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .REG_AW(REG_AW), .TAG_W(TAG_W),
                      .NUM_RD(NUM_RD), .COMMIT_W(COMMIT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Model state: what each register architecturally holds.
  logic [XLEN-1:0]  m_val  [NREG];
  bit               m_busy [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];
  logic [XLEN-1:0]  n_val  [NREG];
  bit               n_busy [NREG];
  logic [TAG_W-1:0] n_tag  [NREG];

  function automatic int youngest_commit(input int r);
    int yp = -1;
    for (int p = 0; p < COMMIT_W; p++)
      if (bus.cm_valid[p] && int'(bus.cm_rd[p*REG_AW +: REG_AW]) == r) yp = p;
    return yp;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_val[r] = '0; m_busy[r] = 0; m_tag[r] = '0;
      end
    end else begin
      n_val = m_val; n_busy = m_busy; n_tag = m_tag;
      if (bus.rdy) begin
        for (int r = 1; r < NREG; r++) begin
          int yp;
          yp = youngest_commit(r);
          if (yp >= 0) begin
            n_val[r] = bus.cm_val[yp*XLEN +: XLEN];
            if (bus.cm_tag[yp*TAG_W +: TAG_W] == m_tag[r] &&
                !(bus.up_valid && int'(bus.up_rd) == r))
              n_busy[r] = 0;
          end
        end
        if (!bus.flush && bus.up_valid && bus.up_rd != 0) begin
          n_busy[bus.up_rd] = 1;
          n_tag[bus.up_rd]  = bus.up_tag;
        end
      end
      if (bus.flush) for (int r = 0; r < NREG; r++) n_busy[r] = 0;
      m_val = n_val; m_busy = n_busy; m_tag = n_tag;
    end
  end

  function automatic int model_cnt();
    int c = 0;
    for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  function automatic void model_read(input int idx, output bit er,
                                     output logic [XLEN-1:0] ev, output logic [TAG_W-1:0] et);
    er = !m_busy[idx];
    ev = m_val[idx];
    et = m_tag[idx];
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (m_busy[idx] && bus.rdy && !(bus.up_valid && int'(bus.up_rd) == idx)) begin
      for (int p = COMMIT_W - 1; p >= 0; p--) begin
        if (bus.cm_valid[p] && int'(bus.cm_rd[p*REG_AW +: REG_AW]) == idx &&
            bus.cm_tag[p*TAG_W +: TAG_W] == m_tag[idx]) begin
          er = 1;
          ev = bus.cm_val[p*XLEN +: XLEN];
          break;
        end
      end
    end
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int k = 0; k < NUM_RD; k++) begin
        bit er; logic [XLEN-1:0] ev; logic [TAG_W-1:0] et; int idx;
        idx = int'(bus.rd_idx[k*REG_AW +: REG_AW]);
        model_read(idx, er, ev, et);
        chk($sformatf("cmp.ready[%0d] x%0d", k, idx), bus.rd_ready[k], er);
        chk($sformatf("cmp.val[%0d] x%0d", k, idx), bus.rd_val[k*XLEN +: XLEN], ev);
        if (!er) chk($sformatf("cmp.tag[%0d] x%0d", k, idx), bus.rd_tag[k*TAG_W +: TAG_W], et);
      end
      chk("cmp.busy_cnt", bus.busy_cnt, model_cnt());
    end
  end

  task automatic idle();
    bus.rdy = 1; bus.flush = 0; bus.cm_valid = '0; bus.cm_rd = '0; bus.cm_tag = '0;
    bus.cm_val = '0; bus.up_valid = 0; bus.up_rd = '0; bus.up_tag = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cm(input int p, input int rd, input int tag, input logic [XLEN-1:0] v);
    bus.cm_valid[p] = 1;
    bus.cm_rd[p*REG_AW +: REG_AW] = REG_AW'(rd);
    bus.cm_tag[p*TAG_W +: TAG_W] = TAG_W'(tag);
    bus.cm_val[p*XLEN +: XLEN] = v;
  endtask

  task automatic up(input int rd, input int tag);
    bus.up_valid = 1; bus.up_rd = REG_AW'(rd); bus.up_tag = TAG_W'(tag);
  endtask

  task automatic peek(input string nm, input int idx, input bit er,
                      input logic [XLEN-1:0] ev, input logic [TAG_W-1:0] et);
    bus.rd_idx[REG_AW-1:0] = REG_AW'(idx);
    #1;
    chk({nm, ".ready"}, bus.rd_ready[0], er);
    chk({nm, ".val"}, bus.rd_val[XLEN-1:0], ev);
    if (!er) chk({nm, ".tag"}, bus.rd_tag[TAG_W-1:0], et);
  endtask

  initial begin
    rst = 1; idle(); bus.rd_idx = '0;
    repeat (3) cyc();
    rst = 0;
    chk_en = 1;
    cyc();

    for (int i = 0; i < NREG; i++) peek($sformatf("reset.x%0d", i), i, 1, 0, 0);
    chk("reset.busy_cnt", bus.busy_cnt, 0);

    up(5, 3); cyc(); idle();
    peek("t2.renamed", 5, 0, 0, 3);
    chk("t2.busy_cnt", bus.busy_cnt, 1);
    cm(0, 5, 3, 32'hDEADBEEF); cyc(); idle();
    peek("t2.committed", 5, 1, 32'hDEADBEEF, 0);

    up(7, 1); cyc(); up(7, 2); cyc(); idle();
    cm(0, 7, 1, 32'h11); cyc(); idle();
    peek("t3.stale_commit", 7, 0, 32'h11, 2);
    cm(0, 7, 2, 32'h22); cyc(); idle();
    peek("t3.final_commit", 7, 1, 32'h22, 0);

    up(4, 2); cyc(); idle();
    cm(0, 4, 1, 32'hA); cm(1, 4, 2, 32'hB); cyc(); idle();
    peek("t4.dual_commit", 4, 1, 32'hB, 0);

    up(9, 5); cyc(); idle();
    cm(0, 9, 5, 32'h99); up(9, 6); cyc(); idle();
    peek("t5.commit_vs_up", 9, 0, 32'h99, 6);
    cm(0, 9, 6, 32'h98); cyc(); idle();
    chk("t5.busy_cnt", bus.busy_cnt, 0);

    bus.rdy = 0; up(6, 1); cm(0, 6, 0, 32'h66); cyc(); idle();
    peek("hold.x6", 6, 1, 0, 0);
    cm(0, 0, 0, 32'hFFFF); up(0, 3); cyc(); idle();
    peek("x0.write", 0, 1, 0, 0);
    chk("x0.busy_cnt", bus.busy_cnt, 0);

    up(1, 1); cyc(); up(2, 2); cyc(); up(3, 3); cyc(); idle();
    chk("t6.busy_cnt3", bus.busy_cnt, 3);
    bus.rdy = 0; bus.flush = 1; cyc(); idle();
    chk("t6.flush_cnt", bus.busy_cnt, 0);
    peek("t6.x1", 1, 1, 0, 0);
    peek("t6.x3", 3, 1, 0, 0);

    up(1, 4); cyc(); idle();
    cm(0, 1, 4, 32'h5); bus.rd_idx[REG_AW-1:0] = 5'd1; #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
    chk("byp.ready", bus.rd_ready[0], 1);
    chk("byp.val", bus.rd_val[XLEN-1:0], 32'h5);
`else
    chk("nobyp.ready", bus.rd_ready[0], 0);
    chk("nobyp.val", bus.rd_val[XLEN-1:0], 32'h0);
`endif
    cyc(); idle();
    peek("byp.after", 1, 1, 32'h5, 0);

    for (int n = 0; n < 2000; n++) begin
      idle();
      bus.rdy   = ($urandom_range(0, 9) != 0);
      bus.flush = ($urandom_range(0, 24) == 0);
      for (int p = 0; p < COMMIT_W; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          int rd;
          rd = int'($urandom_range(0, 7));
          cm(p, rd, ($urandom_range(0, 2) != 0) ? int'(m_tag[rd]) : int'($urandom_range(0, 15)),
             $urandom());
        end
      end
      if ($urandom_range(0, 1) == 1) up(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      for (int k = 0; k < NUM_RD; k++)
        bus.rd_idx[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
      cyc();
    end
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
